// File: rtl/display_scan_ctrl_pkg.sv
// Shared definitions for the multiplexed 7-segment display scanner.
package display_scan_ctrl_pkg;

    typedef enum logic [1:0] {
        st_off   = 2'd0,
        st_drive = 2'd1,
        st_guard = 2'd2
    } scan_state_e;

    // Common-anode digit enables are active low, so "off" is a high level.
    localparam logic       DIG_OFF = 1'b1;
    localparam logic [3:0] BCD_MAX = 4'd9;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/display_scan_ctrl_prescaler.sv
// Slot-duration counter: clears on request, counts while enabled, flags the last cycle.
module display_scan_ctrl_prescaler #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] last,
    output logic         tc
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign tc = en && (cnt_q == last);

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan of NDIG common-anode digits through one shared BCD encoder,
// with dead-time between digits and frame-aligned double-buffered updates.
module display_scan_ctrl
    import display_scan_ctrl_pkg::*;
#(
    parameter int unsigned NDIG     = 4,
    parameter int unsigned PRESCALE = 50000,
    parameter int unsigned GUARD    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              lzb,
    input  logic              load,
    input  logic [4*NDIG-1:0] digits_in,
    output logic [3:0]        bcd_out,
    output logic [NDIG-1:0]   digit_n,
    output logic              frame_done,
    output logic              upd_pending
);

    localparam int unsigned CMAX = max_u(PRESCALE, GUARD);
    localparam int unsigned CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam int unsigned IW   = $clog2(NDIG);

    localparam logic [IW-1:0] IDX_LAST   = IW'(NDIG - 1);
    localparam logic [CW-1:0] DRIVE_LAST = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD - 1);

    scan_state_e       state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic              prime_q, prime_d;
    logic [4*NDIG-1:0] shadow_q, shadow_d;
    logic [4*NDIG-1:0] pending_q, pending_d;
    logic              upd_q, upd_d;
    logic [3:0]        bcd_q, bcd_d;
    logic [NDIG-1:0]   dn_q, dn_d;
    logic              fd_q, fd_d;

    logic              cnt_clr;
    logic [CW-1:0]     cnt_last;
    logic              tc;
    logic              boundary;
    logic              xfer;
    logic [NDIG-1:0]   blank;
    logic [NDIG-1:0]   lit_n;

    // prime_q marks the setup cycle after OFF: bcd_out settles before digit 0 lights,
    // and the counter holds so digit 0 still gets a full slot.
    display_scan_ctrl_prescaler #(
        .W (CW)
    ) u_scan_prescaler (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .en    (~prime_q),
        .last  (cnt_last),
        .tc    (tc)
    );

    assign cnt_last = (state_q == st_guard) ? GUARD_LAST : DRIVE_LAST;
    assign boundary = enable && (state_q == st_drive) && tc && (idx_q == IDX_LAST);
    assign xfer     = (state_q == st_off) || boundary;

    always_comb begin : blank_mask
        logic lead;
        blank = '0;
        lead  = 1'b1;
        for (int i = NDIG - 1; i >= 0; i--) begin
            lead     = lead && (shadow_q[4*i +: 4] == 4'd0);
            blank[i] = (shadow_q[4*i +: 4] > BCD_MAX) || (lzb && (i != 0) && lead);
        end
    end

    assign lit_n = blank[idx_q] ? {NDIG{DIG_OFF}}
                                : ~({{(NDIG-1){1'b0}}, 1'b1} << idx_q);

    // A load coinciding with a transfer point bypasses pending so it is never lost.
    always_comb begin : buffer_next
        shadow_d  = shadow_q;
        pending_d = pending_q;
        upd_d     = upd_q;
        if (xfer) begin
            if (load) begin
                shadow_d  = digits_in;
                pending_d = digits_in;
                upd_d     = 1'b0;
            end else if (upd_q) begin
                shadow_d = pending_q;
                upd_d    = 1'b0;
            end
        end else if (load) begin
            pending_d = digits_in;
            upd_d     = 1'b1;
        end
    end

    always_comb begin : fsm_next
        state_d = state_q;
        idx_d   = idx_q;
        prime_d = 1'b0;
        bcd_d   = bcd_q;
        dn_d    = {NDIG{DIG_OFF}};
        fd_d    = 1'b0;
        cnt_clr = 1'b0;
        if (!enable) begin
            state_d = st_off;
            idx_d   = '0;
            cnt_clr = 1'b1;
        end else begin
            unique case (state_q)
                st_off: begin
                    state_d = st_drive;
                    idx_d   = '0;
                    prime_d = 1'b1;
                    cnt_clr = 1'b1;
                    bcd_d   = shadow_d[3:0];
                end
                st_drive: begin
                    if (tc) begin
                        state_d = st_guard;
                        cnt_clr = 1'b1;
                        idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
                        fd_d    = boundary;
                        bcd_d   = shadow_d[{idx_d, 2'b00} +: 4];
                    end else begin
                        dn_d = lit_n;
                    end
                end
                st_guard: begin
                    if (tc) begin
                        state_d = st_drive;
                        cnt_clr = 1'b1;
                        dn_d    = lit_n;
                    end
                end
                default: begin
                    state_d = st_off;
                    idx_d   = '0;
                    cnt_clr = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= st_off;
            idx_q     <= '0;
            prime_q   <= 1'b0;
            shadow_q  <= '0;
            pending_q <= '0;
            upd_q     <= 1'b0;
            bcd_q     <= 4'd0;
            dn_q      <= {NDIG{DIG_OFF}};
            fd_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            prime_q   <= prime_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            upd_q     <= upd_d;
            bcd_q     <= bcd_d;
            dn_q      <= dn_d;
            fd_q      <= fd_d;
        end
    end

    assign bcd_out     = bcd_q;
    assign digit_n     = dn_q;
    assign frame_done  = fd_q;
    assign upd_pending = upd_q;

endmodule
